// File: rtl/nibble_word_packer.sv
// Packs MSB-first 4-bit nibbles into 16-bit words behind a one-word output register.
// Optional parity output enabled by defining PACKER_PARITY_EN.
module nibble_word_packer #(
    parameter int unsigned NIBBLE_W = 4,
    parameter int unsigned NIBBLES  = 4,
    parameter int unsigned WORD_W   = NIBBLE_W * NIBBLES
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_nib_valid,
    input  logic [NIBBLE_W-1:0] i_nib,
    output logic                o_nib_ready,
    input  logic                i_flush,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [WORD_W-1:0]   o_data,
    output logic [2:0]          o_count
`ifdef PACKER_PARITY_EN
    ,
    output logic                o_parity
`endif
);

    localparam logic [2:0] NibblesC = 3'(NIBBLES);

    logic [WORD_W-1:0] r_asm;
    logic [WORD_W-1:0] r_out;
    logic [2:0]        r_count;
    logic              r_valid;

    logic              w_free;
    logic              w_accept;
    logic              w_full;
    logic              w_complete;
    logic              w_load;
    logic [2:0]        w_count_new;
    logic [WORD_W-1:0] w_asm_new;

    assign w_full      = (r_count == NibblesC);
    assign o_nib_ready = (r_count < NibblesC);
    assign w_free      = ~r_valid | i_ready;
    assign w_accept    = i_nib_valid & o_nib_ready;
    assign w_count_new = r_count + {2'b00, w_accept};

    // Empty slots are already zero (assembly is cleared on load), so padding is implicit.
    always_comb begin
        w_asm_new = r_asm;
        if (w_accept) begin
            for (int k = 0; k < int'(NIBBLES); k++) begin
                if (r_count == 3'(k)) begin
                    w_asm_new[WORD_W-1-k*NIBBLE_W -: NIBBLE_W] = i_nib;
                end
            end
        end
    end

    always_comb begin
        w_complete = 1'b0;
        if (w_full) begin
            w_complete = 1'b1;
        end else if (w_accept && (w_count_new == NibblesC)) begin
            w_complete = 1'b1;
        end else if (i_flush && (w_count_new != 3'd0)) begin
            w_complete = 1'b1;
        end
    end

    assign w_load = w_complete & w_free;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_asm   <= '0;
            r_out   <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_load) begin
                r_out   <= w_asm_new;
                r_valid <= 1'b1;
                r_asm   <= '0;
                r_count <= '0;
            end else begin
                if (r_valid && i_ready) begin
                    r_valid <= 1'b0;
                end
                r_asm   <= w_asm_new;
                // A flushed partial word that cannot leave yet parks as full.
                r_count <= w_complete ? NibblesC : w_count_new;
            end
        end
    end

`ifdef PACKER_PARITY_EN
    logic r_parity;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^w_asm_new;
        end
    end

    assign o_parity = r_parity;
`else
`endif

    assign o_valid = r_valid;
    assign o_data  = r_out;
    assign o_count = r_count;

endmodule

// File: tb/tb_nibble_word_packer.sv
// Directed self-checking bench for nibble_word_packer.
module tb_nibble_word_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        nib_valid;
    logic [3:0]  nib;
    logic        nib_ready;
    logic        flush;
    logic        valid;
    logic        ready;
    logic [15:0] data;
    logic [2:0]  count;
`ifdef PACKER_PARITY_EN
    logic        parity;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nibble_word_packer dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_nib_valid (nib_valid),
        .i_nib       (nib),
        .o_nib_ready (nib_ready),
        .i_flush     (flush),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_data      (data),
        .o_count     (count)
`ifdef PACKER_PARITY_EN
        ,
        .o_parity    (parity)
`endif
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] n);
        nib_valid = 1'b1;
        nib       = n;
        step();
        nib_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
        total++; if (data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", data); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (nib_ready !== 1'b1) begin bad++; $display("FAIL reset_nib_ready got=%b exp=1", nib_ready); end
    endtask

    task automatic test_basic();
        ready = 1'b1;
        send(4'h2);
        send(4'h3);
        send(4'h4);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", valid); end
        total++; if (count !== 3'd3) begin bad++; $display("FAIL basic_count3 got=%0d exp=3", count); end
        send(4'h4);
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", valid); end
        total++; if (data !== 16'h2344) begin bad++; $display("FAIL basic_data got=%h exp=2344", data); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL basic_count0 got=%0d exp=0", count); end
`ifdef PACKER_PARITY_EN
        total++; if (parity !== 1'b1) begin bad++; $display("FAIL parity_2344 got=%b exp=1", parity); end
`endif
        step();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL basic_drop got=%b exp=0", valid); end
    endtask

    task automatic test_backpressure();
        ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(4'(i));
        total++; if (data !== 16'h1234) begin bad++; $display("FAIL bp_held_data got=%h exp=1234", data); end
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL bp_held_valid got=%b exp=1", valid); end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL bp_count got=%0d exp=4", count); end
        total++; if (nib_ready !== 1'b0) begin bad++; $display("FAIL bp_nib_ready got=%b exp=0", nib_ready); end
        send(4'hF);  // refused while full
        total++; if (data !== 16'h1234) begin bad++; $display("FAIL bp_stable got=%h exp=1234", data); end
        ready = 1'b1;
        step();
        total++; if (data !== 16'h5678) begin bad++; $display("FAIL bp_second got=%h exp=5678", data); end
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL bp_second_valid got=%b exp=1", valid); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL bp_drain_count got=%0d exp=0", count); end
        step();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL bp_drop got=%b exp=0", valid); end
    endtask

    task automatic test_flush();
        ready = 1'b1;
        send(4'hA);
        send(4'hB);
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (valid !== 1'b1 || data !== 16'hAB00) begin
            bad++; $display("FAIL flush_ab got=%b/%h exp=1/ab00", valid, data); end
        step();
        flush = 1'b1;
        send(4'hC);
        flush = 1'b0;
        total++; if (valid !== 1'b1 || data !== 16'hC000) begin
            bad++; $display("FAIL flush_c got=%b/%h exp=1/c000", valid, data); end
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (valid !== 1'b0 || count !== 3'd0) begin
            bad++; $display("FAIL flush_empty got=%b/%0d exp=0/0", valid, count); end
    endtask

    task automatic test_reset_mid();
        ready = 1'b1;
        send(4'h1);
        send(4'h2);
        send(4'h3);
        rst = 1'b0;
        step();
        rst = 1'b1;
        total++; if (count !== 3'd0 || valid !== 1'b0) begin
            bad++; $display("FAIL midrst got=%0d/%b exp=0/0", count, valid); end
        step();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL midrst_noemit got=%b exp=0", valid); end
        send(4'h9);
        send(4'h8);
        send(4'h7);
        send(4'h6);
        total++; if (valid !== 1'b1 || data !== 16'h9876) begin
            bad++; $display("FAIL midrst_word got=%b/%h exp=1/9876", valid, data); end
        step();
    endtask

    task automatic test_back_to_back();
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(4'(15 - i));
            if (i == 3) begin
                total++; if (data !== 16'hFEDC) begin bad++; $display("FAIL b2b_first got=%h exp=fedc", data); end
            end
        end
        total++; if (valid !== 1'b1 || data !== 16'hBA98) begin
            bad++; $display("FAIL b2b_second got=%b/%h exp=1/ba98", valid, data); end
        step();
`ifdef PACKER_PARITY_EN
        send(4'h0);
        send(4'h0);
        send(4'h0);
        send(4'h3);
        total++; if (data !== 16'h0003 || parity !== 1'b0) begin
            bad++; $display("FAIL parity_0003 got=%h/%b exp=0003/0", data, parity); end
        step();
`endif
    endtask

    initial begin
        rst       = 1'b0;
        nib_valid = 1'b0;
        nib       = 4'h0;
        flush     = 1'b0;
        ready     = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
